hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage CPU. It drives the PC write enable and the IF/ID stall/flush controls, and inserts ID/EX bubbles. It detects load-use hazards, sequences taken-branch redirects, and holds the front end for a fixed number of cycles while a multi-cycle mult/div occupies EX. State updates on posedge clk. Outputs are Mealy, combinational from state and inputs, and stable before the negedge where the pipeline registers sample them.

---
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, mult/div hold
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  IFID_UsesRt,
  input  logic                  BranchTaken,
  input  logic                  MulDivStart,
  output logic                  PCWrite,
  output logic                  IFIDStall,
  output logic                  IFIDFlush,
  output logic                  IDEXFlush,
  output logic                  MulDivBusy,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // The start cycle itself is the issue advance, so the wait counts down from N-1 to 0.
  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       hz;

  // Load-use hazard: ID reads the register the load in EX is about to write (r0 excluded).
  assign hz = IDEX_MemRead && (IDEX_Rt != '0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  // State and wait-counter register; reset aborts any wait in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and Mealy pipeline controls; stall always wins over flush.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    PCWrite    = 1'b1;
    IFIDStall  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    MulDivBusy = 1'b0;
    if (rst) begin
      PCWrite   = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            PCWrite   = 1'b0;
            IFIDStall = 1'b1;
            IDEXFlush = 1'b1;
          end else if (BranchTaken) begin
            IFIDFlush = 1'b1;
          end else if (MulDivStart) begin
            cnt_next   = MD_LOAD;
            state_next = MD_WAIT;
          end
        end
        MD_WAIT: begin
          PCWrite    = 1'b0;
          IFIDStall  = 1'b1;
          IDEXFlush  = 1'b1;
          MulDivBusy = 1'b1;
          if (cnt == 8'd0) state_next = RUN;
          else             cnt_next   = cnt - 8'd1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters: stalled cycles and flushed cycles outside reset, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (IFIDStall) StallCount <= StallCount + 32'd1;
      if (IFIDFlush) FlushCount <= FlushCount + 32'd1;
    end
  end
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

  localparam int MDC = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // expected control vector: {PCWrite, IFIDStall, IFIDFlush, IDEXFlush, MulDivBusy}
  localparam logic [4:0] E_RUN = 5'b10000;
  localparam logic [4:0] E_HZ  = 5'b01010;
  localparam logic [4:0] E_BR  = 5'b10100;
  localparam logic [4:0] E_MDW = 5'b01011;
  localparam logic [4:0] E_RST = 5'b00110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] idex_rt = '0;
  logic [4:0] ifid_rs = '0;
  logic [4:0] ifid_rt = '0;
  logic       uses_rt = 1'b0;
  logic       br = 1'b0;
  logic       mds = 1'b0;
  logic       pcw, stall, iflush, eflush, busy;
  logic [31:0] scnt, fcnt;

  typedef struct {
    int          id;
    logic [4:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;
  logic [31:0] mdl_sc = 0;
  logic [31:0] mdl_fc = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_CYCLES(MDC), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(mem_read), .IDEX_Rt(idex_rt),
    .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt), .IFID_UsesRt(uses_rt),
    .BranchTaken(br), .MulDivStart(mds),
    .PCWrite(pcw), .IFIDStall(stall), .IFIDFlush(iflush), .IDEXFlush(eflush),
    .MulDivBusy(busy), .StallCount(scnt), .FlushCount(fcnt)
  );

  // Drive one cycle of inputs just after the edge and queue the expected response.
  task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic b, input logic m, input logic [4:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_read = mr; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
    uses_rt = ur; br = b; mds = m;
    if (r) begin
      mdl_sc = 0;
      mdl_fc = 0;
    end
    e.id  = step_id;
    e.ctl = ctl;
    e.sc  = PERF ? mdl_sc : 32'd0;
    e.fc  = PERF ? mdl_fc : 32'd0;
    exp_q.push_back(e);
    if (!r) begin
      mdl_sc = mdl_sc + {31'd0, ctl[3]};
      mdl_fc = mdl_fc + {31'd0, ctl[2]};
    end
    step_id++;
  endtask

  task automatic idle(input logic [4:0] ctl);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ctl);
  endtask

  // Monitor: compare the DUT against the oldest expectation at each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pcw, stall, iflush, eflush, busy} !== e.ctl) begin
        errors++;
        $display("FAIL ctl step %0d: got %b expected %b", e.id,
                 {pcw, stall, iflush, eflush, busy}, e.ctl);
      end
      checks++;
      if (scnt !== e.sc) begin
        errors++;
        $display("FAIL stall_count step %0d: got %0d expected %0d", e.id, scnt, e.sc);
      end
      checks++;
      if (fcnt !== e.fc) begin
        errors++;
        $display("FAIL flush_count step %0d: got %0d expected %0d", e.id, fcnt, e.fc);
      end
      checks++;
      if (stall && iflush && !rst) begin
        errors++;
        $display("FAIL stall_flush_excl step %0d: stall=%b flush=%b", e.id, stall, iflush);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // reset held 3 cycles with a start request present
    repeat (3) step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RST);
    idle(E_RUN);
    // load-use on rs: exactly one bubble
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, E_HZ);
    idle(E_RUN);
    // r0 never hazards
    step(1'b0, 1'b1, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_RUN);
    // rt match only counts when rt is a source
    step(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, E_RUN);
    step(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, E_HZ);
    // no load, matching registers
    step(1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, E_RUN);
    // taken branch: single flush cycle
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_BR);
    idle(E_RUN);
    // branch together with hazard: stall only, branch re-seen next cycle
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, E_HZ);
    step(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, E_BR);
    // branch together with start: start ignored
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_BR);
    idle(E_RUN);
    // hazard together with start: start deferred
    step(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, E_HZ);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
    // mult/div wait of MDC cycles, inputs ignored throughout
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_MDW);
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, E_MDW);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_MDW);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_MDW);
    idle(E_RUN);
    idle(E_RUN);
    // abort wait with reset in second wait cycle
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
    idle(E_MDW);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
    idle(E_RUN);
    idle(E_RUN);
    // performance sequence after a fresh reset: 1 load-use + 1 branch + full wait
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
    idle(E_RUN);
    step(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, E_HZ);
    idle(E_RUN);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_BR);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
    repeat (MDC) idle(E_MDW);
    idle(E_RUN);
    idle(E_RUN);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (scnt !== (PERF ? 32'd5 : 32'd0)) begin
      errors++;
      $display("FAIL perf_stall_total: got %0d expected %0d", scnt, PERF ? 5 : 0);
    end
    checks++;
    if (fcnt !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL perf_flush_total: got %0d expected %0d", fcnt, PERF ? 1 : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
